// File: rtl/dp_ram_pkg.sv
// Shared types and constants for the clearing dual-port RAM.
// Provides the sequencer state encoding and read-during-write mode codes.
package dp_ram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/dp_ram_clr_seq.sv
// Clear sequencer: walks every address once after reset or on request.
// Ports: clk, reset (async, active-high), clear -> init_busy, clr_we, clr_addr.
module dp_ram_clr_seq
    import dp_ram_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    output logic              init_busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            unique case (state_q)
                ST_INIT: begin
                    // Leave INIT after the last word has been written
                    if (ptr_q == LAST) begin
                        state_q <= ST_RUN;
                        ptr_q   <= '0;
                    end else begin
                        ptr_q <= ptr_q + ADDR_W'(1);
                    end
                end
                ST_RUN: begin
                    if (clear) begin
                        state_q <= ST_INIT;
                        ptr_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    assign init_busy = (state_q == ST_INIT);
    assign clr_we    = init_busy;
    assign clr_addr  = ptr_q;

endmodule

// File: rtl/dp_ram_clr.sv
// Simple dual-port RAM with self-clear, read-valid, collision and range flags.
// Ports: clk, reset, clear, we/we_addr/din, re/re_addr -> dout, dout_valid,
//        init_busy, collision, addr_err.
module dp_ram_clr
    import dp_ram_pkg::*;
#(
    parameter  int                DATA_W   = 8,
    parameter  int                DEPTH    = 16,
    parameter  int                RDW_MODE = RDW_READ_FIRST,
    parameter  logic [DATA_W-1:0] CLR_VAL  = '0,
    localparam int                ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              we,
    input  logic [ADDR_W-1:0] we_addr,
    input  logic [DATA_W-1:0] din,
    input  logic              re,
    input  logic [ADDR_W-1:0] re_addr,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              init_busy,
    output logic              collision,
    output logic              addr_err
);

    // One extra bit so DEPTH itself is representable for the range test
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    dp_ram_clr_seq #(
        .DEPTH(DEPTH)
    ) u_seq (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .init_busy(init_busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic run;
    logic we_in;
    logic re_in;
    logic wr_ok;
    logic col_w;

    assign run   = !init_busy;
    assign we_in = ({1'b0, we_addr} < DEPTH_X);
    assign re_in = ({1'b0, re_addr} < DEPTH_X);
    assign wr_ok = run & we & we_in;
    assign col_w = re & we & re_in & (re_addr == we_addr);

    // Clear sequencer owns the write port while busy
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign mem_we    = clr_we | wr_ok;
    assign mem_waddr = clr_we ? clr_addr : we_addr;
    assign mem_wdata = clr_we ? CLR_VAL : din;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              col_q, col_d;
    logic              err_q, err_d;

    always_comb begin
        dout_d  = dout_q;
        valid_d = 1'b0;
        col_d   = 1'b0;
        err_d   = 1'b0;
        if (run) begin
            valid_d = re;
            col_d   = col_w;
            err_d   = (re & !re_in) | (we & !we_in);
            if (re) begin
                if (!re_in) begin
                    dout_d = '0;
                end else if (col_w && RDW_MODE == RDW_WRITE_FIRST) begin
                    dout_d = din;
                end else begin
                    dout_d = mem[re_addr];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            col_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
            col_q   <= col_d;
            err_q   <= err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign collision  = col_q;
    assign addr_err   = err_q;

endmodule

// File: tb/tb_dp_ram_clr.sv
// Directed bench for dp_ram_clr: read-first and write-first 16-word
// instances plus a 12-word instance, all sharing one stimulus bus.
module tb_dp_ram_clr;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       we = 1'b0;
    logic [3:0] we_addr = '0;
    logic [7:0] din = '0;
    logic       re = 1'b0;
    logic [3:0] re_addr = '0;

    logic [7:0] d0_dout, d1_dout, d2_dout;
    logic       d0_vld, d1_vld, d2_vld;
    logic       d0_busy, d1_busy, d2_busy;
    logic       d0_col, d1_col, d2_col;
    logic       d0_err, d1_err, d2_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dp_ram_clr #(.DATA_W(8), .DEPTH(16), .RDW_MODE(0)) u_d0 (
        .clk(clk), .reset(reset), .clear(clear),
        .we(we), .we_addr(we_addr), .din(din),
        .re(re), .re_addr(re_addr),
        .dout(d0_dout), .dout_valid(d0_vld), .init_busy(d0_busy),
        .collision(d0_col), .addr_err(d0_err)
    );

    dp_ram_clr #(.DATA_W(8), .DEPTH(16), .RDW_MODE(1)) u_d1 (
        .clk(clk), .reset(reset), .clear(clear),
        .we(we), .we_addr(we_addr), .din(din),
        .re(re), .re_addr(re_addr),
        .dout(d1_dout), .dout_valid(d1_vld), .init_busy(d1_busy),
        .collision(d1_col), .addr_err(d1_err)
    );

    dp_ram_clr #(.DATA_W(8), .DEPTH(12), .RDW_MODE(0)) u_d2 (
        .clk(clk), .reset(reset), .clear(clear),
        .we(we), .we_addr(we_addr), .din(din),
        .re(re), .re_addr(re_addr),
        .dout(d2_dout), .dout_valid(d2_vld), .init_busy(d2_busy),
        .collision(d2_col), .addr_err(d2_err)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, sample 1ns after the rising edge
    task automatic step(input logic w, input logic [3:0] wa,
                        input logic [7:0] wd, input logic r,
                        input logic [3:0] ra, input logic c);
        @(negedge clk);
        we = w; we_addr = wa; din = wd;
        re = r; re_addr = ra; clear = c;
        @(posedge clk);
        #1;
        we = 1'b0; re = 1'b0; clear = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dout"}, d0_dout, 0);
        chk({tag, "_vld"}, d0_vld, 0);
        chk({tag, "_busy"}, d0_busy, 1);
        chk({tag, "_col"}, d0_col, 0);
        chk({tag, "_err"}, d0_err, 0);
    endtask

    // Counts rising edges until each instance leaves INIT
    task automatic count_init(input string tag, input int e16,
                              input int e12);
        int n0 = 0, n1 = 0, n2 = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (!d0_busy && n0 == 0) n0 = k;
            if (!d1_busy && n1 == 0) n1 = k;
            if (!d2_busy && n2 == 0) n2 = k;
            if (n0 != 0 && n1 != 0 && n2 != 0) break;
        end
        chk({tag, "_len16_rf"}, n0, e16);
        chk({tag, "_len16_wf"}, n1, e16);
        chk({tag, "_len12"}, n2, e12);
    endtask

    initial begin
        // T1: reset values, INIT length, memory cleared
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        @(negedge clk);
        reset = 1'b0;
        count_init("t1", 16, 12);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 4'd0, 8'd0, 1'b1, 4'(i), 1'b0);
            chk($sformatf("t1_rd%0d", i), d0_dout, 0);
            chk($sformatf("t1_vld%0d", i), d0_vld, 1);
            if (i < 12) chk($sformatf("t1_d2_rd%0d", i), d2_dout, 0);
        end

        // T2: pattern write and read back
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'(i), 8'(i * 3 + 1), 1'b0, 4'd0, 1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 4'd0, 8'd0, 1'b1, 4'(i), 1'b0);
            chk($sformatf("t2_rf%0d", i), d0_dout, i * 3 + 1);
            chk($sformatf("t2_wf%0d", i), d1_dout, i * 3 + 1);
            chk($sformatf("t2_vld%0d", i), d0_vld, 1);
        end
        idle();
        chk("t2_hold", d0_dout, 46);
        chk("t2_gap_vld", d0_vld, 0);

        // T3: same-address read and write
        step(1'b1, 4'd5, 8'hAA, 1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd5, 8'h55, 1'b1, 4'd5, 1'b0);
        chk("t3_rf_old", d0_dout, 'hAA);
        chk("t3_wf_new", d1_dout, 'h55);
        chk("t3_rf_col", d0_col, 1);
        chk("t3_wf_col", d1_col, 1);
        idle();
        chk("t3_col_pulse_rf", d0_col, 0);
        chk("t3_col_pulse_wf", d1_col, 0);
        step(1'b0, 4'd0, 8'd0, 1'b1, 4'd5, 1'b0);
        chk("t3_rf_after", d0_dout, 'h55);
        chk("t3_wf_after", d1_dout, 'h55);

        // T5: out-of-range accesses on the 12-word instance
        step(1'b1, 4'd13, 8'h77, 1'b0, 4'd0, 1'b0);
        chk("t5_wr_err", d2_err, 1);
        chk("t5_wr_err_inrange", d0_err, 0);
        idle();
        chk("t5_err_pulse", d2_err, 0);
        step(1'b0, 4'd0, 8'd0, 1'b1, 4'd13, 1'b0);
        chk("t5_rd_dout", d2_dout, 0);
        chk("t5_rd_vld", d2_vld, 1);
        chk("t5_rd_err", d2_err, 1);
        step(1'b1, 4'd14, 8'h11, 1'b1, 4'd14, 1'b0);
        chk("t5_oob_col", d2_col, 0);
        chk("t5_oob_col_err", d2_err, 1);
        chk("t5_inrange_col", d0_col, 1);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 4'd0, 8'd0, 1'b1, 4'(i), 1'b0);
            chk($sformatf("t5_keep%0d", i), d2_dout,
                (i == 5) ? 'h55 : i * 3 + 1);
        end

        // T4: clear request; writes while busy are ignored
        step(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b1);
        chk("t4_busy", d0_busy, 1);
        begin
            int n = 0;
            for (int k = 1; k <= 40; k++) begin
                step(1'b1, 4'(k - 1), 8'hFF, 1'b1, 4'(k - 1), 1'b0);
                if (k == 1) chk("t4_vld_busy", d0_vld, 0);
                if (!d0_busy) begin
                    n = k;
                    break;
                end
            end
            chk("t4_len", n, 16);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 4'd0, 8'd0, 1'b1, 4'(i), 1'b0);
            chk($sformatf("t4_rf%0d", i), d0_dout, 0);
            chk($sformatf("t4_wf%0d", i), d1_dout, 0);
        end

        // T6: reset while the clear pointer sits at 7
        step(1'b1, 4'd3, 8'h3C, 1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 8'd0, 1'b1, 4'd3, 1'b0);
        chk("t6_pre_rd", d0_dout, 'h3C);
        step(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b1);
        repeat (7) idle();
        chk("t6_hold_busy", d0_dout, 'h3C);
        reset = 1'b1;
        #1;
        chk_reset_vals("t6");
        @(negedge clk);
        reset = 1'b0;
        count_init("t6", 16, 12);
        step(1'b0, 4'd0, 8'd0, 1'b1, 4'd3, 1'b0);
        chk("t6_rd3", d0_dout, 0);
        chk("t6_rd3_vld", d0_vld, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
